poly_sub_ctrl: RTL and testbench

Sequencer that performs element-wise polynomial subtraction C[i] = (A[i] - B[i]) mod Q over N coefficients.

- Drives one shared read address into the A and B coefficient memories.
- Feeds the returned operands through an internal `mod_sub` instance (same WIDTH/Q).
- Writes each registered result to the C memory.
- Sits beside the NTT core in the polynomial arithmetic unit, started by the top-level controller with a start/done handshake.

---
 rtl/poly_sub_ctrl.sv | 141 ++++++++++++++
 tb/tb_poly_sub_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_sub_ctrl.sv
// poly_sub_ctrl: sequencer for element-wise C[i] = (A[i] - B[i]) mod Q.
// Issues one shared read address per cycle to the A/B memories. The returned
// operands pass through mod_sub, and each registered result is written to C.
// The pipeline behind the issue stage never stalls.

module mod_sub #(
  parameter int WIDTH = 32,
  parameter int Q     = 3329
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam logic signed [WIDTH+1:0] Q_S = $signed((WIDTH+2)'(Q));

  // Operands are below Q, so a single conditional add of Q folds a negative
  // difference back into [0, Q-1].
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    logic signed [WIDTH+1:0] d;
    d = $signed({2'b00, x}) - $signed({2'b00, z});
    if (d < 0) d = d + Q_S;
    return d[WIDTH-1:0];
  endfunction

  // Combinational modular difference.
  always_comb y = sub_mod(a, b);

endmodule

module poly_sub_ctrl #(
  parameter int WIDTH  = 32,
  parameter int Q      = 3329,
  parameter int N      = 256,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic [WIDTH-1:0]  b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(N - 1);

  logic [1:0]        state;
  logic [ADDR_W:0]   issue_cnt;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              vld_p2;
  logic [ADDR_W-1:0] addr_p2;
  logic [WIDTH-1:0]  data_p2;
  logic [WIDTH-1:0]  diff;

  // Issue strobe and status decode straight from state so that an
  // asynchronous reset silences them at once.
  always_comb begin
    rd_en   = (state == S_ISSUE) && !stall;
    rd_addr = issue_cnt[ADDR_W-1:0];
    busy    = (state == S_ISSUE) || (state == S_DRAIN);
    done    = (state == S_DONE);
    wr_en   = vld_p2;
    wr_addr = addr_p2;
    wr_data = data_p2;
  end

  // Control FSM and issue counter. DRAIN leaves once stage 1 is empty:
  // nothing new enters in DRAIN, so after that edge both valids are 0 and
  // the final write has been presented to C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ISSUE;
            issue_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (rd_en) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_ADDR) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!vld_p1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage 1: read issued, operands arrive next cycle ----
  // Stage 1 address only matters when vld_p1 is set, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_p1 <= rd_addr;
  end

  mod_sub #(.WIDTH(WIDTH), .Q(Q)) u_mod_sub (
    .a (a_data),
    .b (b_data),
    .y (diff)
  );

  // ---- stage 2: registered modular difference drives the C write ----
  // Valids clear on reset so in-flight entries are discarded. The write port
  // is reset too so that it reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
    end else begin
      vld_p1 <= rd_en;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        addr_p2 <= addr_p1;
        data_p2 <= diff;
      end
    end
  end

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Directed bench for poly_sub_ctrl: an N=4 instance for cycle-exact timing
// and an N=256 instance for full-length passes with random data and stall.

module tb_poly_sub_ctrl;

  localparam int Q = 3329;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instance, N=4.
  logic        start_s, stall_s, busy_s, done_s, rd_en_s, wr_en_s;
  logic [1:0]  rd_addr_s, wr_addr_s;
  logic [31:0] a_s, b_s, wd_s;
  logic [31:0] mem_a_s [4];
  logic [31:0] mem_b_s [4];
  logic [31:0] exp_c_s [4];

  // Large instance, N=256.
  logic        start_l, stall_l, busy_l, done_l, rd_en_l, wr_en_l;
  logic [7:0]  rd_addr_l, wr_addr_l;
  logic [31:0] a_l, b_l, wd_l;
  logic [31:0] mem_a_l [256];
  logic [31:0] mem_b_l [256];

  int tests = 0;
  int fails = 0;

  poly_sub_ctrl #(.WIDTH(32), .Q(Q), .N(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .stall(stall_s),
    .busy(busy_s), .done(done_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
    .a_data(a_s), .b_data(b_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
    .wr_data(wd_s)
  );

  poly_sub_ctrl #(.WIDTH(32), .Q(Q), .N(256)) dut_l (
    .clk(clk), .rst(rst), .start(start_l), .stall(stall_l),
    .busy(busy_l), .done(done_l), .rd_en(rd_en_l), .rd_addr(rd_addr_l),
    .a_data(a_l), .b_data(b_l), .wr_en(wr_en_l), .wr_addr(wr_addr_l),
    .wr_data(wd_l)
  );

  // Synchronous-read A/B memories: data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en_s) begin
      a_s <= mem_a_s[rd_addr_s];
      b_s <= mem_b_s[rd_addr_s];
    end
    if (rd_en_l) begin
      a_l <= mem_a_l[rd_addr_l];
      b_l <= mem_b_l[rd_addr_l];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    int r;
    r = (int'(a) + Q - int'(b)) % Q;
    return 32'(r);
  endfunction

  // Drive start/stall per cycle from bit masks and compare each cycle against
  // hand-derived masks. Bit c refers to cycle c; start bit 0 is sampled at edge 0.
  task automatic run_small(input string nm, input logic [31:0] start_m,
                           input logic [31:0] stall_m, input logic [31:0] rd_m,
                           input logic [31:0] wr_m, input logic [31:0] busy_m,
                           input logic [31:0] done_m, input int ncyc);
    int ri, wi;
    ri = 0;
    wi = 0;
    @(negedge clk);
    start_s = start_m[0];
    stall_s = stall_m[0];
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start_s = start_m[c];
      stall_s = stall_m[c];
      #1;
      chk($sformatf("%s rd_en c%0d", nm, c), 32'(rd_en_s), 32'(rd_m[c]));
      chk($sformatf("%s wr_en c%0d", nm, c), 32'(wr_en_s), 32'(wr_m[c]));
      chk($sformatf("%s busy c%0d", nm, c), 32'(busy_s), 32'(busy_m[c]));
      chk($sformatf("%s done c%0d", nm, c), 32'(done_s), 32'(done_m[c]));
      if (rd_en_s) begin
        chk($sformatf("%s rd_addr c%0d", nm, c), 32'(rd_addr_s), 32'(ri % 4));
        ri++;
      end
      if (wr_en_s) begin
        chk($sformatf("%s wr_addr c%0d", nm, c), 32'(wr_addr_s), 32'(wi % 4));
        chk($sformatf("%s wr_data c%0d", nm, c), wd_s, exp_c_s[wr_addr_s]);
        wi++;
      end
    end
    start_s = 1'b0;
    stall_s = 1'b0;
    chk($sformatf("%s write count", nm), 32'(wi), 32'($countones(wr_m)));
  endtask

  // Full N=256 pass; randomized stall when rnd_stall is set.
  task automatic run_large(input string nm, input bit rnd_stall);
    int wi, ri, dn, c, done_at;
    wi = 0; ri = 0; dn = 0; c = 0; done_at = -1;
    @(negedge clk);
    start_l = 1'b1;
    stall_l = 1'b0;
    while (c < 3000 && !(done_at >= 0 && c > done_at + 10)) begin
      @(negedge clk);
      c++;
      start_l = 1'b0;
      stall_l = rnd_stall ? ($urandom_range(0, 99) < 30) : 1'b0;
      #1;
      if (rd_en_l) begin
        if (rd_addr_l != 8'(ri)) chk($sformatf("%s rd_addr", nm), 32'(rd_addr_l), 32'(ri));
        ri++;
      end
      if (wr_en_l) begin
        chk($sformatf("%s wr_addr #%0d", nm, wi), 32'(wr_addr_l), 32'(wi));
        chk($sformatf("%s wr_data @%0d", nm, wr_addr_l), wd_l,
            ref_sub(mem_a_l[wr_addr_l], mem_b_l[wr_addr_l]));
        wi++;
      end
      if (done_l) begin
        dn++;
        done_at = c;
        chk($sformatf("%s busy at done", nm), 32'(busy_l), 32'd0);
      end
    end
    stall_l = 1'b0;
    chk($sformatf("%s reached done (timeout)", nm), 32'(done_at >= 0), 32'd1);
    chk($sformatf("%s done pulses", nm), 32'(dn), 32'd1);
    chk($sformatf("%s write count", nm), 32'(wi), 32'd256);
    chk($sformatf("%s read count", nm), 32'(ri), 32'd256);
  endtask

  initial begin
    rst = 1'b1;
    start_s = 1'b0; stall_s = 1'b0;
    start_l = 1'b0; stall_l = 1'b0;

    // Reset state.
    #12;
    chk("reset busy", 32'(busy_s), 32'd0);
    chk("reset done", 32'(done_s), 32'd0);
    chk("reset rd_en", 32'(rd_en_s), 32'd0);
    chk("reset rd_addr", 32'(rd_addr_s), 32'd0);
    chk("reset wr_en", 32'(wr_en_s), 32'd0);
    chk("reset wr_addr", 32'(wr_addr_s), 32'd0);
    chk("reset wr_data", wd_s, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pass: C = {7, 3328, 0, 3328}.
    mem_a_s = '{32'd10, 32'd0, 32'd3328, 32'd5};
    mem_b_s = '{32'd3, 32'd1, 32'd3328, 32'd6};
    exp_c_s = '{32'd7, 32'd3328, 32'd0, 32'd3328};
    run_small("basic", 32'h1, 32'h0, 32'h1E, 32'h78, 32'h7E, 32'h80, 10);

    // Stall in cycles 2-3: reads 1,4,5,6; writes 3,6,7,8; done 9.
    run_small("stall", 32'h1, 32'h0C, 32'h72, 32'h1C8, 32'h1FE, 32'h200, 12);

    // start held for edges 0..19: passes start at edges 0, 8, 16.
    run_small("hold", 32'h000F_FFFF, 32'h0, 32'h001E_1E1E, 32'h0078_7878,
              32'h007E_7E7E, 32'h0080_8080, 28);

    // Asynchronous reset in cycle 3 of a pass.
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy_s), 32'd0);
    chk("abort done", 32'(done_s), 32'd0);
    chk("abort rd_en", 32'(rd_en_s), 32'd0);
    chk("abort rd_addr", 32'(rd_addr_s), 32'd0);
    chk("abort wr_en", 32'(wr_en_s), 32'd0);
    chk("abort wr_addr", 32'(wr_addr_s), 32'd0);
    chk("abort wr_data", wd_s, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort quiet wr_en %0d", k), 32'(wr_en_s), 32'd0);
      chk($sformatf("abort quiet done %0d", k), 32'(done_s), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-abort idle wr_en %0d", k), 32'(wr_en_s), 32'd0);
      chk($sformatf("post-abort idle done %0d", k), 32'(done_s), 32'd0);
    end
    run_small("after-abort", 32'h1, 32'h0, 32'h1E, 32'h78, 32'h7E, 32'h80, 10);

    // Boundary operands on the small instance.
    mem_a_s = '{32'd0, 32'd3328, 32'd1234, 32'd0};
    mem_b_s = '{32'd3328, 32'd0, 32'd1234, 32'd0};
    exp_c_s = '{32'd1, 32'd3328, 32'd0, 32'd0};
    run_small("bound4", 32'h1, 32'h0, 32'h1E, 32'h78, 32'h7E, 32'h80, 10);

    // N=256, random operands, ~30% stall.
    for (int i = 0; i < 256; i++) begin
      mem_a_l[i] = 32'($urandom_range(0, Q - 1));
      mem_b_l[i] = 32'($urandom_range(0, Q - 1));
    end
    run_large("rand256", 1'b1);

    // N=256 boundaries cycling through the three edge cases.
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       begin mem_a_l[i] = 32'd0;      mem_b_l[i] = 32'(Q - 1); end
        1:       begin mem_a_l[i] = 32'(Q - 1); mem_b_l[i] = 32'd0;      end
        default: begin mem_a_l[i] = 32'(i);     mem_b_l[i] = 32'(i);     end
      endcase
    end
    run_large("bound256", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
